// File: rtl/bus_write_buffer_pkg.sv
// Shared types for the bus write buffer.
//   state_e    : controller state encoding (IDLE / DRAIN / READ)
//   wr_entry_t : one buffered write {address, wdata, wmask}
//   ENTRY_W    : packed width of wr_entry_t (68 bits)
package bus_write_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_READ  = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

endpackage

// File: rtl/bus_write_buffer_sync_fifo.sv
// Synchronous FIFO holding posted writes.
//   i_clock, i_reset : clock, synchronous active-low reset
//   i_push, i_wdata  : write an entry (ignored when full)
//   i_pop            : drop the head entry (ignored when empty)
//   o_rdata          : head entry, valid combinationally while !o_empty
//   o_full, o_empty, o_count : occupancy
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 68,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointers wrap by plain overflow.
        if (do_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge i_clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bus_write_buffer.sv
// Posted-write buffer between one requester and one arbiter port.
// Writes are acknowledged as soon as there is FIFO space and drained
// in order; reads wait until every buffered write has reached the bus.
//   i_clock, i_reset (sync, active-low)
//   upstream   : i_rw, i_request, o_ready, i_address, o_rdata, i_wdata, i_wmask
//   downstream : o_bus_rw, o_bus_request, i_bus_ready, o_bus_address,
//                i_bus_rdata, o_bus_wdata, o_bus_wmask
//   o_empty    : nothing buffered and no drain in flight
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | bus quiet; pick drain (if FIFO non-empty) or pending read
// DRAIN | FIFO head presented on the bus until i_bus_ready
// READ  | upstream read passed through until i_bus_ready
module bus_write_buffer
    import bus_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rw,
    input  logic        i_request,
    output logic        o_ready,
    input  logic [31:0] i_address,
    output logic [31:0] o_rdata,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    output logic        o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e           state_q, state_d;
    wr_entry_t        push_entry, head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push, pop;

    assign push_entry = '{address: i_address, wdata: i_wdata, wmask: i_wmask};
    assign head_entry = wr_entry_t'(head_bits);
    assign o_rdata    = i_bus_rdata;
    // Forced to 1 during reset so the flag never shows stale occupancy.
    assign o_empty    = !i_reset || (fifo_empty && (state_q != ST_DRAIN));

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (push),
        .i_wdata (push_entry),
        .i_pop   (pop),
        .o_rdata (head_bits),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        o_bus_wmask   = '0;
        // Write acceptance depends only on space, never on the state;
        // a full FIFO stalls even when the head pops this cycle.
        push          = i_request && i_rw && !fifo_full;
        o_ready       = push;

        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    state_d = ST_DRAIN;
                end else if (i_request && !i_rw) begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                o_bus_request = 1'b1;
                o_bus_rw      = 1'b1;
                o_bus_address = head_entry.address;
                o_bus_wdata   = head_entry.wdata;
                o_bus_wmask   = head_entry.wmask;
                if (i_bus_ready) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                o_bus_request = i_request;
                o_bus_address = i_address;
                o_ready       = i_bus_ready;
                if (i_bus_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!i_reset) begin
            state_d       = ST_IDLE;
            push          = 1'b0;
            pop           = 1'b0;
            o_ready       = 1'b0;
            o_bus_request = 1'b0;
            o_bus_rw      = 1'b0;
            o_bus_address = '0;
            o_bus_wdata   = '0;
            o_bus_wmask   = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
